uart_tx_arb: RTL
================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
Parameters:
REQ-001 NUM_REQ, 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 DATA_W, 8, payload width per byte.
REQ-003 ACK_TIMEOUT, 1024, maximum cycles to wait for tx_send_ack before abort.

Ports:
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req  in  NUM_REQ  per-requester byte-send request, level.
REQ-007 req_data  in  NUM_REQ*DATA_W  per-requester byte; slice i belongs to requester i.
REQ-008 gnt  out  NUM_REQ  one-hot, one-cycle pulse; byte of requester i accepted.
REQ-009 done  out  NUM_REQ  one-hot, one-cycle pulse; granted byte fully transmitted.
REQ-010 err  out  NUM_REQ  one-hot, one-cycle pulse; granted byte aborted on ack timeout.
REQ-011 tx_send  out  1  request to transmitter; held until acknowledged.
REQ-012 tx_din  out  DATA_W  byte to transmitter; stable while tx_send high.
REQ-013 tx_send_ack  in  1  transmitter has latched tx_din into its frame.
REQ-014 tx_done  in  1  one-cycle pulse; stop bit of current frame completed.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 owner  out  $clog2(NUM_REQ)  index of current grant holder; 0 when idle.

Function
REQ-017 FSM states: IDLE, SEND, WAIT_DONE.
REQ-018 IDLE: if any req bit high, select winner round-robin starting at pointer ptr; on next edge pulse gnt[winner], latch req_data slice into tx_din, set owner, go SEND.
REQ-019 Round-robin: winner = first set req bit at index >= ptr, wrapping modulo NUM_REQ; ptr resets to 0.
REQ-020 ptr updates to (winner+1) mod NUM_REQ only when the transaction ends (done or err), wrapping NUM_REQ-1 -> 0.
REQ-021 SEND: tx_send high, tx_din held; on tx_send_ack, drop tx_send next cycle and go WAIT_DONE.
REQ-022 SEND timeout: counter counts cycles in SEND; reaching ACK_TIMEOUT without ack pulses err[owner], drops tx_send, returns IDLE.
REQ-023 WAIT_DONE: on tx_done pulse done[owner] and return IDLE.
REQ-024 tx_send_ack and tx_done in the same SEND cycle: treat as complete; pulse done, go IDLE.
REQ-025 tx_done outside WAIT_DONE (and outside REQ-024) is ignored.
REQ-026 Latency: req high in IDLE at edge n -> gnt and tx_send high after edge n+1; minimum req-to-req turnaround 1 idle cycle after done.
REQ-027 Requester dropping req or changing req_data after gnt has no effect; latched byte is sent.
REQ-028 At most one bit of gnt, done, err high in any cycle; never gnt and done in the same cycle.
REQ-029 Requester holding req after done is rearbitrated normally; with all requests high, grants rotate 0,1,2,3,0.

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, ptr 0, owner 0, timeout counter 0, tx_din 0, tx_send/gnt/done/err/busy 0.
REQ-031 Reset mid-transaction abandons the byte silently; no done or err is issued after release.
REQ-032 First arbitration after reset release occurs on the first edge with rst_n high.

Structure
REQ-033 Shared package uart_pkg holds the FSM state enum, default DATA_W and default ACK_TIMEOUT constants.
REQ-034 Sub-module uart_rr_arbiter: combinational round-robin selector (req vector, ptr in; one-hot grant and index out), instantiated once.

Verification
REQ-035 Single requester: req[2]=1, data 8'hA5; ack after 3 cycles, tx_done after 100 -> gnt[2] one pulse, tx_din=8'hA5 during tx_send, done[2] once, ptr=3.
REQ-036 All four req held, data 8'h10..8'h13 -> grant order 0,1,2,3,0; tx_din sequence 10,11,12,13,10.
REQ-037 Ack never returned, ACK_TIMEOUT=16 -> err[owner] exactly 16 cycles after tx_send rise, tx_send low, next request granted.
REQ-038 tx_send_ack and tx_done asserted same cycle -> done pulse, IDLE next cycle, no WAIT_DONE stall.
REQ-039 rst_n low during WAIT_DONE -> all outputs 0 immediately; no done after release; next grant starts at requester 0.
REQ-040 req_data changed from 8'h3C to 8'hFF one cycle after gnt -> transmitter receives 8'h3C.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2
    } arb_state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ACK_TIMEOUT = 1024;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin selector: first set request at or above ptr,
// wrapping modulo NUM_REQ.
module uart_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    logic [NUM_REQ-1:0] rot;
    int                 off;
    int                 sum;

    // Rotate so ptr lands on bit 0, then the lowest set bit is the winner.
    always_comb begin
        rot     = NUM_REQ'({req, req} >> ptr);
        off     = 0;
        gnt_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off     = i;
                gnt_vld = 1'b1;
            end
        end
        sum = int'(ptr) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        gnt_idx = IDX_W'(sum);
        gnt_oh  = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one UART transmitter among NUM_REQ byte requesters, round-robin,
// with an acknowledge timeout on the send handshake.
//
//   state        | meaning
//   ST_IDLE      | no transaction; arbitrate pending requests each edge
//   ST_SEND      | tx_send high, waiting for tx_send_ack (timeout armed)
//   ST_WAIT_DONE | byte latched by transmitter, waiting for tx_done
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic [NUM_REQ-1:0]           err,
    output logic                         tx_send,
    output logic [DATA_W-1:0]            tx_din,
    input  logic                         tx_send_ack,
    input  logic                         tx_done,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   owner
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    ptr_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_REQ-1:0]  arb_oh;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_vld;
    logic [DATA_W-1:0]   win_data;
    logic [NUM_REQ-1:0]  owner_oh;
    logic                take_gnt;
    logic                fin_done;
    logic                fin_err;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req     (req),
        .ptr     (ptr),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign owner_oh = NUM_REQ'(1) << owner;
    assign ptr_nxt  = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign tx_send  = (state == ST_SEND);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ack wins over a coincident timeout; ack with tx_done closes the byte at once.
    always_comb begin
        state_nxt = state;
        take_gnt  = 1'b0;
        fin_done  = 1'b0;
        fin_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_vld) begin
                    take_gnt  = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_send_ack && tx_done) begin
                    fin_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tx_send_ack) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (cnt == CNT_W'(1)) begin
                    fin_err   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    fin_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            owner  <= '0;
            cnt    <= '0;
            tx_din <= '0;
            gnt    <= '0;
            done   <= '0;
            err    <= '0;
        end else begin
            gnt  <= '0;
            done <= fin_done ? owner_oh : '0;
            err  <= fin_err  ? owner_oh : '0;
            if (take_gnt) begin
                gnt    <= arb_oh;
                owner  <= arb_idx;
                tx_din <= win_data;
                cnt    <= CNT_W'(ACK_TIMEOUT);
            end else if (state == ST_SEND) begin
                cnt <= cnt - 1'b1;
            end
            if (fin_done || fin_err) begin
                ptr   <= ptr_nxt;
                owner <= '0;
                cnt   <= '0;
            end
        end
    end

endmodule
